// File: rtl/alu_arbiter.sv
// Two-port front end sharing one ALU, with a one-entry registered response buffer.
// Opcodes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101,
// SLTU 0110, SLL 0111, SRL 1000, SRA 1001, JALR 1010; anything else yields 0.

// Shared single-cycle combinational ALU
module alu (
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic [3:0]  alu_control,
    output logic [31:0] result
);
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_JALR = 4'b1010;

    logic [DATA_W-1:0]  sum;
    logic [SHAMT_W-1:0] shamt;

    assign sum   = operand_a + operand_b;
    assign shamt = operand_b[SHAMT_W-1:0];

    // Opcode decode; unknown opcodes return zero
    always_comb begin
        result = '0;
        case (alu_control)
            OP_ADD:  result = sum;
            OP_SUB:  result = operand_a - operand_b;
            OP_AND:  result = operand_a & operand_b;
            OP_OR:   result = operand_a | operand_b;
            OP_XOR:  result = operand_a ^ operand_b;
            OP_SLT:  result = DATA_W'($signed(operand_a) < $signed(operand_b));
            OP_SLTU: result = DATA_W'(operand_a < operand_b);
            OP_SLL:  result = operand_a << shamt;
            OP_SRL:  result = operand_a >> shamt;
            OP_SRA:  result = DATA_W'($signed(operand_a) >>> shamt);
            OP_JALR: result = {sum[DATA_W-1:1], 1'b0};
            default: result = '0;
        endcase
    end
endmodule

// Arbiter: grants one port per cycle into the ALU, result lands in the response register
module alu_arbiter #(
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_operand_a,
    input  logic [31:0] req0_operand_b,
    input  logic [3:0]  req0_alu_control,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_operand_a,
    input  logic [31:0] req1_operand_b,
    input  logic [3:0]  req1_alu_control,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_result,
    output logic        busy
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTL_W  = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               last_grant_q;
    logic               grant;
    logic               can_accept;
    logic               handshake;
    logic [DATA_W-1:0]  mux_a;
    logic [DATA_W-1:0]  mux_b;
    logic [CTL_W-1:0]   mux_ctl;
    logic [DATA_W-1:0]  alu_result;

    // Grant select: single requester wins, ties go by priority mode
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Operand mux from the granted port into the shared ALU
    always_comb begin
        mux_a   = req0_operand_a;
        mux_b   = req0_operand_b;
        mux_ctl = req0_alu_control;
        if (grant) begin
            mux_a   = req1_operand_a;
            mux_b   = req1_operand_b;
            mux_ctl = req1_alu_control;
        end
    end

    alu u_alu (
        .operand_a   (mux_a),
        .operand_b   (mux_b),
        .alu_control (mux_ctl),
        .result      (alu_result)
    );

    // Response buffer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake; rst_n gates ready so nothing completes during reset
    always_comb begin
        state_d    = state_q;
        can_accept = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        handshake  = 1'b0;

        can_accept = rst_n && ((state_q == EMPTY) || resp_ready);
        req0_ready = can_accept && req0_valid && !grant;
        req1_ready = can_accept && req1_valid && grant;
        handshake  = req0_ready || req1_ready;

        case (state_q)
            EMPTY: begin
                if (handshake) state_d = FULL;
            end
            FULL: begin
                if (handshake)       state_d = FULL;
                else if (resp_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Response payload and round-robin history, loaded only on a handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_result  <= '0;
            resp_id      <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (handshake) begin
            resp_result  <= alu_result;
            resp_id      <= grant;
            last_grant_q <= grant;
        end
    end

    assign resp_valid = (state_q == FULL);
    assign busy       = resp_valid || req0_valid || req1_valid;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin and fixed-priority instances share stimulus,
// each checked against a cycle-level reference model of the response buffer.
module tb_alu_arbiter;
    logic        clk;
    logic        rst_n;
    logic        v0, v1, resp_ready;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  c0, c1;
    logic [1:0]  rdy0, rdy1, rv, rid, bsy;
    logic [31:0] res [2];

    int tests;
    int fails;

    // reference model state, index 0 = round-robin, 1 = fixed priority
    bit          m_full [2];
    logic [31:0] m_res  [2];
    bit          m_id   [2];
    bit          m_last [2];

    alu_arbiter #(.FIXED_PRIORITY(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_ready(rdy0[0]), .req0_operand_a(a0), .req0_operand_b(b0), .req0_alu_control(c0),
        .req1_valid(v1), .req1_ready(rdy1[0]), .req1_operand_a(a1), .req1_operand_b(b1), .req1_alu_control(c1),
        .resp_valid(rv[0]), .resp_ready(resp_ready), .resp_id(rid[0]), .resp_result(res[0]), .busy(bsy[0])
    );

    alu_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_ready(rdy0[1]), .req0_operand_a(a0), .req0_operand_b(b0), .req0_alu_control(c0),
        .req1_valid(v1), .req1_ready(rdy1[1]), .req1_operand_a(a1), .req1_operand_b(b1), .req1_alu_control(c1),
        .resp_valid(rv[1]), .resp_ready(resp_ready), .resp_id(rid[1]), .resp_result(res[1]), .busy(bsy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        sh = int'(b % 32);
        case (ctl)
            4'd0:  return 32'(ua + ub);
            4'd1:  return 32'(ua - ub);
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd6:  return (ua < ub) ? 32'd1 : 32'd0;
            4'd7:  return 32'(ua * (64'd1 << sh));
            4'd8:  return 32'(ua / (64'd1 << sh));
            4'd9:  return 32'(sa >>> sh);
            4'd10: return 32'(((ua + ub) / 2) * 2);
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit ref_grant(input int k);
        if (v0 && v1) return (k == 1) ? 1'b0 : !m_last[k];
        return v1 ? 1'b1 : 1'b0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_full[k] = 1'b0;
            m_res[k]  = 32'd0;
            m_id[k]   = 1'b0;
            m_last[k] = 1'b1;
        end
    endtask

    // One clock: check outputs against the model, advance the model at the edge
    task automatic step();
        bit g [2];
        bit hs [2];
        logic [31:0] nres [2];
        #1;
        for (int k = 0; k < 2; k++) begin
            bit acc;
            bit e0, e1;
            acc   = rst_n && (!m_full[k] || resp_ready);
            g[k]  = ref_grant(k);
            e0    = acc && v0 && !g[k];
            e1    = acc && v1 && g[k];
            hs[k] = e0 || e1;
            nres[k] = g[k] ? ref_alu(c1, a1, b1) : ref_alu(c0, a0, b0);
            chk($sformatf("req0_ready[%0d]", k), 32'(rdy0[k]), 32'(e0));
            chk($sformatf("req1_ready[%0d]", k), 32'(rdy1[k]), 32'(e1));
            chk($sformatf("resp_valid[%0d]", k), 32'(rv[k]), 32'(m_full[k]));
            chk($sformatf("busy[%0d]", k), 32'(bsy[k]), 32'(m_full[k] || v0 || v1));
            if (m_full[k]) begin
                chk($sformatf("resp_id[%0d]", k), 32'(rid[k]), 32'(m_id[k]));
                chk($sformatf("resp_result[%0d]", k), res[k], m_res[k]);
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (hs[k]) begin
                m_full[k] = 1'b1;
                m_res[k]  = nres[k];
                m_id[k]   = g[k];
                m_last[k] = g[k];
            end else if (m_full[k] && resp_ready) begin
                m_full[k] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // Reset asserted between edges; outputs must clear without a clock
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_rv[%0d]", tag, k), 32'(rv[k]), 32'd0);
            chk($sformatf("%s_res[%0d]", tag, k), res[k], 32'd0);
            chk($sformatf("%s_id[%0d]", tag, k), 32'(rid[k]), 32'd0);
            chk($sformatf("%s_rdy[%0d]", tag, k), 32'({rdy1[k], rdy0[k]}), 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        v0 = v; a0 = a; b0 = b; c0 = c;
    endtask

    task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
        v1 = v; a1 = a; b1 = b; c1 = c;
    endtask

    logic [31:0] bnd_a   [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_1001, 32'h1234_5678};
    logic [31:0] bnd_b   [4] = '{32'd1, 32'd1, 32'd2, 32'd9};
    logic [3:0]  bnd_c   [4] = '{4'b0110, 4'b0101, 4'b1010, 4'b1111};
    logic [31:0] bnd_exp [4] = '{32'd0, 32'd1, 32'h0000_1002, 32'd0};
    bit          rr_seq  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        resp_ready = 1'b1;
        set0(1'b1, 32'd1, 32'd1, 4'd0);
        set1(1'b1, 32'd2, 32'd2, 4'd0);
        model_reset();

        // reset values with requests pending
        #2;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_rv[%0d]", k), 32'(rv[k]), 32'd0);
            chk($sformatf("rst_res[%0d]", k), res[k], 32'd0);
            chk($sformatf("rst_id[%0d]", k), 32'(rid[k]), 32'd0);
            chk($sformatf("rst_rdy0[%0d]", k), 32'(rdy0[k]), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // single SUB on port 0
        set0(1'b1, 32'd5, 32'd3, 4'b0001);
        set1(1'b0, 32'd0, 32'd0, 4'd0);
        step();
        set0(1'b0, 32'd0, 32'd0, 4'd0);
        chk("single_rv", 32'(rv[0]), 32'd1);
        chk("single_id", 32'(rid[0]), 32'd0);
        chk("single_res", res[0], 32'd2);

        // round robin vs fixed priority with both ports saturating
        async_reset("rr_rst");
        for (int i = 0; i < 4; i++) begin
            set0(1'b1, 32'(100 + i), 32'd1, 4'd0);
            set1(1'b1, 32'(200 + i), 32'd1, 4'd0);
            step();
            chk($sformatf("rr_id_%0d", i), 32'(rid[0]), 32'(rr_seq[i]));
            chk($sformatf("rr_rv_%0d", i), 32'(rv[0]), 32'd1);
            chk($sformatf("fp_id_%0d", i), 32'(rid[1]), 32'd0);
            chk($sformatf("fp_res_%0d", i), res[1], 32'(101 + i));
        end

        // drain, then backpressure with a held SRA result
        set0(1'b0, 32'd0, 32'd0, 4'd0);
        set1(1'b0, 32'd0, 32'd0, 4'd0);
        step();
        set0(1'b1, 32'h8000_0000, 32'd4, 4'b1001);
        step();
        set0(1'b0, 32'd0, 32'd0, 4'd0);
        set1(1'b1, 32'd7, 32'd1, 4'd0);
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_rdy1_%0d", i), 32'(rdy1[0]), 32'd0);
            chk($sformatf("bp_res_%0d", i), res[0], 32'hF800_0000);
            step();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_rdy1", 32'(rdy1[0]), 32'd1);
        step();
        chk("bp_new_res", res[0], 32'd8);
        chk("bp_new_id", 32'(rid[0]), 32'd1);

        // async reset while full, then tie goes to port 0
        resp_ready = 1'b0;
        step();
        async_reset("full_rst");
        resp_ready = 1'b1;
        set0(1'b1, 32'd10, 32'd20, 4'd0);
        set1(1'b1, 32'd30, 32'd40, 4'd0);
        #1;
        chk("post_rst_rdy0", 32'(rdy0[0]), 32'd1);
        chk("post_rst_rdy1", 32'(rdy1[0]), 32'd0);
        step();
        chk("post_rst_res", res[0], 32'd30);

        // boundary opcodes on port 0
        set1(1'b0, 32'd0, 32'd0, 4'd0);
        for (int i = 0; i < 4; i++) begin
            set0(1'b1, bnd_a[i], bnd_b[i], bnd_c[i]);
            step();
            chk($sformatf("bnd_%0d", i), res[0], bnd_exp[i]);
        end

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            set0(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                 4'($urandom_range(0, 15)));
            set1(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                 4'($urandom_range(0, 15)));
            resp_ready = ($urandom_range(0, 9) < 6);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
